// File: rtl/dcache_pkg.sv
// Shared state encoding, default geometry and address-field helpers for the data cache
// and its miss controller.
package dcache_pkg;

    localparam int DC_DW_OFFSET_WIDTH = 3;
    localparam int DC_LINE_WIDTH      = 6;
    localparam int DC_TAG_WIDTH       = 32 - DC_DW_OFFSET_WIDTH - 3 - DC_LINE_WIDTH;
    localparam int DC_BLOCK_SIZE      = 1 << DC_DW_OFFSET_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS_REQ,
        REFILL,
        FILL_WRITE,
        STORE_REQ,
        STORE_ACK
    } dcache_state_e;

    function automatic logic [DC_TAG_WIDTH-1:0] get_tag(input logic [31:0] addr);
        return addr[31 -: DC_TAG_WIDTH];
    endfunction

    function automatic logic [DC_LINE_WIDTH-1:0] get_index(input logic [31:0] addr);
        return addr[DC_LINE_WIDTH+DC_DW_OFFSET_WIDTH+2 : DC_DW_OFFSET_WIDTH+3];
    endfunction

    function automatic logic [DC_DW_OFFSET_WIDTH-1:0] get_offset(input logic [31:0] addr);
        return addr[DC_DW_OFFSET_WIDTH+2 : 3];
    endfunction

endpackage

// File: rtl/dcache_store_merge.sv
// Byte-granular merge of a store double word into the current array contents.
module dcache_store_merge (
    input  logic [63:0] old_dw_i,
    input  logic [63:0] new_dw_i,
    input  logic [7:0]  wstrb_i,
    output logic [63:0] merged_o
);

    always_comb begin
        merged_o = old_dw_i;
        for (int i = 0; i < 8; i++) begin
            if (wstrb_i[i]) begin
                merged_o[i*8 +: 8] = new_dw_i[i*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/dcache_miss_controller.sv
// Single-outstanding load/store controller for a direct-mapped, write-through,
// no-write-allocate data cache; refills whole blocks on load misses.
module dcache_miss_controller
    import dcache_pkg::*;
#(
    parameter int  double_word_offset_width = DC_DW_OFFSET_WIDTH,
    parameter int  line_width               = DC_LINE_WIDTH,
    localparam int tag_width                = 32 - double_word_offset_width - 3 - line_width,
    localparam int block_size               = 1 << double_word_offset_width
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [31:0]                 req_address,
    input  logic                        req_write,
    input  logic [63:0]                 req_wdata,
    input  logic [7:0]                  req_wstrb,
    output logic                        resp_valid,
    output logic [63:0]                 resp_data,
    output logic [31:0]                 cache_address,
    input  logic [63:0]                 cache_data,
    input  logic [tag_width-1:0]        cache_tag,
    input  logic                        cache_tag_valid,
    output logic                        cache_write_in,
    output logic [line_width-1:0]       cache_write_line_index,
    output logic [64*block_size-1:0]    cache_write_block,
    output logic [tag_width-1:0]        cache_write_tag,
    output logic [block_size-1:0]       cache_write_mask,
    output logic                        mem_req_valid,
    input  logic                        mem_req_ready,
    output logic [31:0]                 mem_req_address,
    output logic                        mem_req_write,
    output logic [63:0]                 mem_req_wdata,
    output logic [7:0]                  mem_req_wstrb,
    input  logic                        mem_resp_valid,
    input  logic [63:0]                 mem_resp_data
);

    localparam int IDX_LO = double_word_offset_width + 3;
    localparam int IDX_HI = line_width + double_word_offset_width + 2;
    localparam logic [double_word_offset_width-1:0] LAST_BEAT = '1;

    dcache_state_e                       state_q, state_d;
    logic [31:3]                         addr_q, addr_d;
    logic                                write_q, write_d;
    logic [63:0]                         wdata_q, wdata_d;
    logic [7:0]                          wstrb_q, wstrb_d;
    logic [double_word_offset_width-1:0] beat_q, beat_d;
    logic [63:0]                         buffer_q [block_size];
    logic [63:0]                         buffer_d [block_size];
    logic                                resp_valid_q, resp_valid_d;
    logic [63:0]                         resp_data_q, resp_data_d;

    logic [double_word_offset_width-1:0] offset;
    logic [line_width-1:0]               index;
    logic [tag_width-1:0]                tag;
    logic                                hit;
    logic [63:0]                         merged_dw;
    logic                                write_en;

    assign offset = addr_q[IDX_LO-1:3];
    assign index  = addr_q[IDX_HI:IDX_LO];
    assign tag    = addr_q[31 -: tag_width];
    assign hit    = cache_tag_valid && (cache_tag == tag);

    dcache_store_merge u_store_merge (
        .old_dw_i (cache_data),
        .new_dw_i (wdata_q),
        .wstrb_i  (wstrb_q),
        .merged_o (merged_dw)
    );

    always_comb begin
        state_d                = state_q;
        addr_d                 = addr_q;
        write_d                = write_q;
        wdata_d                = wdata_q;
        wstrb_d                = wstrb_q;
        beat_d                 = beat_q;
        buffer_d               = buffer_q;
        resp_valid_d           = 1'b0;
        resp_data_d            = '0;
        req_ready              = 1'b0;
        cache_address          = {addr_q, 3'b000};
        write_en               = 1'b0;
        cache_write_line_index = index;
        cache_write_tag        = tag;
        cache_write_block      = '0;
        cache_write_mask       = '0;
        mem_req_valid          = 1'b0;
        mem_req_address        = '0;
        mem_req_write          = 1'b0;
        mem_req_wdata          = '0;
        mem_req_wstrb          = '0;

        unique case (state_q)
            IDLE: begin
                req_ready     = 1'b1;
                cache_address = req_address;
                if (req_valid) begin
                    addr_d  = req_address[31:3];
                    write_d = req_write;
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (write_q) begin
                    if (hit) begin
                        write_en                                  = 1'b1;
                        cache_write_mask[offset]                  = 1'b1;
                        cache_write_block[int'(offset)*64 +: 64]  = merged_dw;
                    end
                    state_d = STORE_REQ;
                end else if (hit) begin
                    resp_valid_d = 1'b1;
                    resp_data_d  = cache_data;
                    state_d      = IDLE;
                end else begin
                    state_d = MISS_REQ;
                end
            end
            MISS_REQ: begin
                mem_req_valid   = 1'b1;
                mem_req_address = {addr_q[31:IDX_LO], {IDX_LO{1'b0}}};
                if (mem_req_ready) begin
                    beat_d  = '0;
                    state_d = REFILL;
                end
            end
            REFILL: begin
                if (mem_resp_valid) begin
                    buffer_d[beat_q] = mem_resp_data;
                    beat_d           = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        state_d = FILL_WRITE;
                    end
                end
            end
            FILL_WRITE: begin
                write_en         = 1'b1;
                cache_write_mask = '1;
                for (int i = 0; i < block_size; i++) begin
                    cache_write_block[i*64 +: 64] = buffer_q[i];
                end
                resp_valid_d = 1'b1;
                resp_data_d  = buffer_q[offset];
                state_d      = IDLE;
            end
            STORE_REQ: begin
                mem_req_valid   = 1'b1;
                mem_req_write   = 1'b1;
                mem_req_address = {addr_q, 3'b000};
                mem_req_wdata   = wdata_q;
                mem_req_wstrb   = wstrb_q;
                if (mem_req_ready) begin
                    state_d = STORE_ACK;
                end
            end
            STORE_ACK: begin
                if (mem_resp_valid) begin
                    resp_valid_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Reset is synchronous, so the state register may still be stale in the reset cycle.
        if (!reset) begin
            req_ready     = 1'b0;
            mem_req_valid = 1'b0;
            write_en      = 1'b0;
        end
    end

    assign cache_write_in = write_en;
    assign resp_valid     = resp_valid_q && reset;
    assign resp_data      = reset ? resp_data_q : '0;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            write_q      <= 1'b0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            beat_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            write_q      <= write_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            beat_q       <= beat_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    // The refill buffer is pure datapath and is always fully overwritten before use.
    always_ff @(posedge clock) begin
        buffer_q <= buffer_d;
    end

endmodule

// File: tb/tb_dcache_miss_controller.sv
// Scoreboard bench for dcache_miss_controller with a behavioural tag/data array and
// a scripted memory responder.
module tb_dcache_miss_controller;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic           req_valid;
    logic           req_ready;
    logic [31:0]    req_address;
    logic           req_write;
    logic [63:0]    req_wdata;
    logic [7:0]     req_wstrb;
    logic           resp_valid;
    logic [63:0]    resp_data;
    logic [31:0]    cache_address;
    logic [63:0]    cache_data;
    logic [19:0]    cache_tag;
    logic           cache_tag_valid;
    logic           cache_write_in;
    logic [5:0]     cache_write_line_index;
    logic [511:0]   cache_write_block;
    logic [19:0]    cache_write_tag;
    logic [7:0]     cache_write_mask;
    logic           mem_req_valid;
    logic           mem_req_ready;
    logic [31:0]    mem_req_address;
    logic           mem_req_write;
    logic [63:0]    mem_req_wdata;
    logic [7:0]     mem_req_wstrb;
    logic           mem_resp_valid;
    logic [63:0]    mem_resp_data;

    always #5 clock = ~clock;

    dcache_miss_controller dut (
        .clock                  (clock),
        .reset                  (reset),
        .req_valid              (req_valid),
        .req_ready              (req_ready),
        .req_address            (req_address),
        .req_write              (req_write),
        .req_wdata              (req_wdata),
        .req_wstrb              (req_wstrb),
        .resp_valid             (resp_valid),
        .resp_data              (resp_data),
        .cache_address          (cache_address),
        .cache_data             (cache_data),
        .cache_tag              (cache_tag),
        .cache_tag_valid        (cache_tag_valid),
        .cache_write_in         (cache_write_in),
        .cache_write_line_index (cache_write_line_index),
        .cache_write_block      (cache_write_block),
        .cache_write_tag        (cache_write_tag),
        .cache_write_mask       (cache_write_mask),
        .mem_req_valid          (mem_req_valid),
        .mem_req_ready          (mem_req_ready),
        .mem_req_address        (mem_req_address),
        .mem_req_write          (mem_req_write),
        .mem_req_wdata          (mem_req_wdata),
        .mem_req_wstrb          (mem_req_wstrb),
        .mem_resp_valid         (mem_resp_valid),
        .mem_resp_data          (mem_resp_data)
    );

    typedef struct {
        logic [63:0] data;
        int          lat;
    } respExp_t;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
    } memExp_t;

    typedef struct {
        logic [5:0]   idx;
        logic [19:0]  tag;
        logic [7:0]   mask;
        logic [511:0] block;
    } wrExp_t;

    respExp_t respQ[$];
    memExp_t  memQ[$];
    wrExp_t   wrQ[$];

    int compared   = 0;
    int mismatched = 0;
    int cycleCount = 0;
    int lastAccept = 0;
    int respSeen   = 0;
    int respTarget = 0;

    int          readyDelay = 0;
    int          beatIdx    = 0;
    int          waitCnt    = 0;
    int          beatsLeft  = 0;
    logic        ackPending = 1'b0;
    logic        strayPulse = 1'b0;
    logic [63:0] beatBase   = '0;

    logic [63:0] arrData  [64][8];
    logic [19:0] arrTag   [64];
    logic        arrValid [64];
    logic        arrCleared = 1'b0;

    logic        holdValid = 1'b0;
    logic [31:0] heldAddr;
    logic        heldWrite;
    logic [63:0] heldWdata;
    logic [7:0]  heldWstrb;

    task automatic checkOutput(input string name, input logic [511:0] actual, input logic [511:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic flagFail(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: got event expected none (or timeout)", name);
    endtask

    always @(posedge clock) cycleCount <= cycleCount + 1;

    // Behavioural tag/data array: registered read, masked block write.
    always @(posedge clock) begin
        if (!arrCleared) begin
            for (int i = 0; i < 64; i++) arrValid[i] <= 1'b0;
            arrCleared <= 1'b1;
        end else if (cache_write_in) begin
            for (int s = 0; s < 8; s++) begin
                if (cache_write_mask[s]) arrData[cache_write_line_index][s] <= cache_write_block[s*64 +: 64];
            end
            arrTag[cache_write_line_index]   <= cache_write_tag;
            arrValid[cache_write_line_index] <= 1'b1;
        end
        cache_data      <= arrData[cache_address[11:6]][cache_address[5:3]];
        cache_tag       <= arrTag[cache_address[11:6]];
        cache_tag_valid <= arrValid[cache_address[11:6]];
    end

    // Memory responder: ready after readyDelay cycles, then 8 ascending beats or one ack.
    initial begin
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        forever begin
            @(posedge clock);
            #1;
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
            if (!reset) begin
                waitCnt    = 0;
                beatsLeft  = 0;
                ackPending = 1'b0;
            end else if (beatsLeft > 0) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = beatBase + 64'(beatIdx);
                beatIdx++;
                beatsLeft--;
            end else if (ackPending) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = 64'hDEAD;
                ackPending     = 1'b0;
            end else if (mem_req_valid) begin
                if (waitCnt < readyDelay) begin
                    waitCnt++;
                end else begin
                    mem_req_ready = 1'b1;
                    waitCnt       = 0;
                    if (mem_req_write) begin
                        ackPending = 1'b1;
                    end else begin
                        beatsLeft = 8;
                        beatIdx   = 0;
                    end
                end
            end else if (strayPulse) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = 64'hBAD;
                strayPulse     = 1'b0;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a response, write or request.
    initial begin
        respExp_t     re;
        memExp_t      me;
        wrExp_t       we;
        logic [511:0] m;
        forever begin
            @(negedge clock);
            if (reset) begin
                if (resp_valid) begin
                    respSeen++;
                    if (respQ.size() == 0) begin
                        flagFail("unexpected resp_valid");
                    end else begin
                        re = respQ.pop_front();
                        checkOutput("resp_data", resp_data, re.data);
                        if (re.lat != 0) checkOutput("resp latency", cycleCount - lastAccept, re.lat);
                    end
                end
                if (req_valid && req_ready) lastAccept = cycleCount;
                if (cache_write_in) begin
                    if (wrQ.size() == 0) begin
                        flagFail("unexpected cache_write_in");
                    end else begin
                        we = wrQ.pop_front();
                        m  = '0;
                        for (int s = 0; s < 8; s++) if (we.mask[s]) m[s*64 +: 64] = '1;
                        checkOutput("cache_write_line_index", cache_write_line_index, we.idx);
                        checkOutput("cache_write_tag", cache_write_tag, we.tag);
                        checkOutput("cache_write_mask", cache_write_mask, we.mask);
                        checkOutput("cache_write_block", cache_write_block & m, we.block & m);
                    end
                end
                if (mem_req_valid && mem_req_ready) begin
                    if (memQ.size() == 0) begin
                        flagFail("unexpected mem request");
                    end else begin
                        me = memQ.pop_front();
                        checkOutput("mem_req_address", mem_req_address, me.addr);
                        checkOutput("mem_req_write", mem_req_write, me.write);
                        if (me.write) begin
                            checkOutput("mem_req_wdata", mem_req_wdata, me.wdata);
                            checkOutput("mem_req_wstrb", mem_req_wstrb, me.wstrb);
                        end
                    end
                end
                if (mem_req_valid && !mem_req_ready) begin
                    if (holdValid) begin
                        checkOutput("mem_req_address stable", mem_req_address, heldAddr);
                        checkOutput("mem_req_write stable", mem_req_write, heldWrite);
                        checkOutput("mem_req_wdata stable", mem_req_wdata, heldWdata);
                        checkOutput("mem_req_wstrb stable", mem_req_wstrb, heldWstrb);
                    end
                    heldAddr  = mem_req_address;
                    heldWrite = mem_req_write;
                    heldWdata = mem_req_wdata;
                    heldWstrb = mem_req_wstrb;
                    holdValid = 1'b1;
                end else begin
                    holdValid = 1'b0;
                end
            end else begin
                holdValid = 1'b0;
            end
        end
    end

    task automatic expectResp(input logic [63:0] data, input int lat);
        respExp_t e;
        e.data = data;
        e.lat  = lat;
        respQ.push_back(e);
        respTarget++;
    endtask

    task automatic expectMem(input logic [31:0] addr, input logic wr, input logic [63:0] wd, input logic [7:0] ws);
        memExp_t e;
        e.addr  = addr;
        e.write = wr;
        e.wdata = wd;
        e.wstrb = ws;
        memQ.push_back(e);
    endtask

    task automatic expectWrite(input logic [5:0] idx, input logic [19:0] tag, input logic [7:0] mask, input logic [511:0] block);
        wrExp_t e;
        e.idx   = idx;
        e.tag   = tag;
        e.mask  = mask;
        e.block = block;
        wrQ.push_back(e);
    endtask

    function automatic logic [511:0] rampBlock(input logic [63:0] base);
        logic [511:0] b;
        for (int i = 0; i < 8; i++) b[i*64 +: 64] = base + 64'(i);
        return b;
    endfunction

    task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [63:0] wd, input logic [7:0] ws);
        int budget;
        @(posedge clock);
        #1;
        req_valid   = 1'b1;
        req_write   = wr;
        req_address = addr;
        req_wdata   = wd;
        req_wstrb   = ws;
        budget      = 0;
        do begin
            @(negedge clock);
            budget++;
        end while (!req_ready && budget < 50);
        if (!req_ready) flagFail("request not accepted");
        @(posedge clock);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic waitResp();
        int n;
        n = 0;
        while (respSeen < respTarget && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (respSeen < respTarget) flagFail("response timeout");
        repeat (2) @(negedge clock);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [511:0] blk;
        int           n;
        req_valid   = 1'b0;
        req_address = '0;
        req_write   = 1'b0;
        req_wdata   = '0;
        req_wstrb   = '0;
        reset       = 1'b0;

        repeat (2) @(posedge clock);
        @(negedge clock);
        checkOutput("reset resp_valid", resp_valid, 1'b0);
        checkOutput("reset resp_data", resp_data, 64'h0);
        checkOutput("reset mem_req_valid", mem_req_valid, 1'b0);
        checkOutput("reset cache_write_in", cache_write_in, 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        checkOutput("idle req_ready", req_ready, 1'b1);

        $display("[TB] load miss 0x1048");
        readyDelay = 0;
        beatBase   = 64'h100;
        expectMem(32'h0000_1040, 1'b0, '0, '0);
        expectWrite(6'd1, 20'h1, 8'hFF, rampBlock(64'h100));
        expectResp(64'h101, 12);
        applyStimulus(1'b0, 32'h0000_1048, '0, '0);
        waitResp();

        $display("[TB] load hit 0x1048");
        expectResp(64'h101, 2);
        applyStimulus(1'b0, 32'h0000_1048, '0, '0);
        waitResp();

        $display("[TB] store hit 0x1048");
        blk = '0;
        blk[127:64] = 64'h0000_0000_FFFF_FFFF;
        expectWrite(6'd1, 20'h1, 8'h02, blk);
        expectMem(32'h0000_1048, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
        expectResp(64'h0, 4);
        applyStimulus(1'b1, 32'h0000_1048, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
        waitResp();

        expectResp(64'h0000_0000_FFFF_FFFF, 2);
        applyStimulus(1'b0, 32'h0000_1048, '0, '0);
        waitResp();

        $display("[TB] store miss 0x20000");
        expectMem(32'h0002_0000, 1'b1, 64'h1234_5678_9ABC_DEF0, 8'hFF);
        expectResp(64'h0, 4);
        applyStimulus(1'b1, 32'h0002_0000, 64'h1234_5678_9ABC_DEF0, 8'hFF);
        waitResp();

        $display("[TB] load miss 0x2010 with 5-cycle ready delay");
        readyDelay = 5;
        beatBase   = 64'h200;
        expectMem(32'h0000_2000, 1'b0, '0, '0);
        expectWrite(6'd0, 20'h2, 8'hFF, rampBlock(64'h200));
        expectResp(64'h202, 17);
        applyStimulus(1'b0, 32'h0000_2010, '0, '0);
        waitResp();
        readyDelay = 0;

        $display("[TB] stray mem_resp_valid in idle");
        strayPulse = 1'b1;
        repeat (4) @(negedge clock);
        checkOutput("stray req_ready", req_ready, 1'b1);
        checkOutput("stray no resp", respSeen, respTarget);

        $display("[TB] reset during refill");
        beatBase = 64'h500;
        expectMem(32'h0000_5080, 1'b0, '0, '0);
        applyStimulus(1'b0, 32'h0000_5088, '0, '0);
        n = 0;
        while (beatIdx != 3 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (beatIdx != 3) flagFail("refill beat timeout");
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        checkOutput("mid reset resp_valid", resp_valid, 1'b0);
        checkOutput("mid reset cache_write_in", cache_write_in, 1'b0);
        checkOutput("mid reset mem_req_valid", mem_req_valid, 1'b0);
        @(posedge clock);
        #1;
        @(negedge clock);
        checkOutput("mid reset cache_write_in 2", cache_write_in, 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        checkOutput("post reset req_ready", req_ready, 1'b1);
        repeat (12) @(negedge clock);
        checkOutput("post reset no resp", respSeen, respTarget);

        beatBase = 64'h600;
        expectMem(32'h0000_5080, 1'b0, '0, '0);
        expectWrite(6'd2, 20'h5, 8'hFF, rampBlock(64'h600));
        expectResp(64'h601, 12);
        applyStimulus(1'b0, 32'h0000_5088, '0, '0);
        waitResp();

        checkOutput("resp queue drained", respQ.size(), 0);
        checkOutput("mem queue drained", memQ.size(), 0);
        checkOutput("write queue drained", wrQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
